// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_master
// Description : APB3 initiator. Accepts one command at a time on a
//               valid/ready request channel, runs a single APB transfer
//               (SETUP then ACCESS), and returns the completion on a
//               valid/ready response channel. An optional ACCESS-phase
//               timeout aborts transfers to unresponsive slaves.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   HCLK, HRESET           clock, synchronous active-high reset
//   req_valid/req_ready    command handshake
//   req_addr/wdata/write   command payload
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata/err/timeout  response payload
//   PADDR..PENABLE         APB3 requester outputs
//   PRDATA/PREADY/PSLVERR  APB3 completer inputs
// All outputs are registered.
// ============================================================================
module apb_cmd_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    input  logic                      req_write,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // Counter must hold values up to TIMEOUT_CYCLES-1; keep at least 1 bit
    // so the design still elaborates with the timeout disabled.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_CNT_W-1:0]        w_cnt_nxt;

    logic                      w_req_ready_nxt;
    logic                      w_rsp_valid_nxt;
    logic [31:0]               w_rsp_rdata_nxt;
    logic                      w_rsp_err_nxt;
    logic                      w_rsp_timeout_nxt;
    logic [APB_ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [31:0]               w_pwdata_nxt;
    logic                      w_pwrite_nxt;
    logic                      w_psel_nxt;
    logic                      w_penable_nxt;

    // State and output registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            req_ready   <= w_req_ready_nxt;
            rsp_valid   <= w_rsp_valid_nxt;
            rsp_rdata   <= w_rsp_rdata_nxt;
            rsp_err     <= w_rsp_err_nxt;
            rsp_timeout <= w_rsp_timeout_nxt;
            PADDR       <= w_paddr_nxt;
            PWDATA      <= w_pwdata_nxt;
            PWRITE      <= w_pwrite_nxt;
            PSEL        <= w_psel_nxt;
            PENABLE     <= w_penable_nxt;
        end
    end

    // Next-state and next-output logic. Every registered output holds its
    // value unless a transition below changes it, which is what keeps the
    // APB payload and the response fields stable across wait cycles.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_req_ready_nxt   = req_ready;
        w_rsp_valid_nxt   = rsp_valid;
        w_rsp_rdata_nxt   = rsp_rdata;
        w_rsp_err_nxt     = rsp_err;
        w_rsp_timeout_nxt = rsp_timeout;
        w_paddr_nxt       = PADDR;
        w_pwdata_nxt      = PWDATA;
        w_pwrite_nxt      = PWRITE;
        w_psel_nxt        = PSEL;
        w_penable_nxt     = PENABLE;

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                if (req_valid && req_ready) begin
                    w_paddr_nxt     = req_addr;
                    w_pwdata_nxt    = req_wdata;
                    w_pwrite_nxt    = req_write;
                    w_psel_nxt      = 1'b1;
                    w_req_ready_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_SETUP;
                end
            end

            S_SETUP: begin
                w_cnt_nxt     = '0;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_state_nxt   = S_ACCESS;
            end

            S_ACCESS: begin
                // PREADY is checked first so a completion on the last
                // allowed cycle is reported as a normal transfer.
                if (PREADY) begin
                    w_rsp_rdata_nxt   = PWRITE ? 32'd0 : PRDATA;
                    w_rsp_err_nxt     = PSLVERR;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_state_nxt       = S_RESP;
                end else if (c_TO_EN && (r_cnt == c_CNT_LAST)) begin
                    w_rsp_rdata_nxt   = 32'd0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_valid_nxt   = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_state_nxt       = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RESP: begin
                // req_ready stays low here: no new command is taken while
                // a response is still pending.
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_cmd_master
// Description : Self-checking bench for apb_cmd_master. A memory-backed APB
//               slave with programmable wait states and error answers the
//               bus; expected responses, latencies and phase counts come from
//               a transaction-level model kept in this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

    localparam int c_TO = 8;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    apb_cmd_master #(
        .APB_ADDR_WIDTH (32),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_write   (req_write),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- APB slave: 16-word memory, programmable waits -------
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    logic        mem_load = 1'b0;
    int          slv_waits = 0;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;

    always @(posedge HCLK) begin
        acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
        if (mem_load) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= ref_mem[i];
        end else if (PSEL && PENABLE && PREADY && PWRITE) begin
            slv_mem[PADDR[5:2]] <= PWDATA;
        end
    end

    assign PREADY  = PSEL && PENABLE && (acc_cnt == slv_waits);
    assign PRDATA  = slv_mem[PADDR[5:2]];
    assign PSLVERR = slv_err && PREADY;

    // ---------------- checking helper ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete command: issue, watch the bus, check the response against
    // the model, optionally stall the response channel, then consume it.
    task automatic run_xfer(input string name, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic wr,
                            input int waits, input logic err, input int hold,
                            output int acc_cyc);
        int          k;
        int          psel_n;
        int          pen_n;
        int          access;
        bit          got;
        bit          order_ok;
        bit          stable_ok;
        bit          timed_out;
        logic [31:0] exp_rdata;
        logic        exp_err;

        // Transaction-level model.
        timed_out = (waits + 1 > c_TO);
        access    = timed_out ? c_TO : waits + 1;
        exp_rdata = (wr || timed_out) ? 32'd0 : ref_mem[addr[5:2]];
        exp_err   = timed_out ? 1'b1 : err;

        slv_waits = waits;
        slv_err   = err;
        acc_cyc   = 0;

        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge HCLK);
            if (req_ready) got = 1;
        end
        chk({name, " req_ready"}, 64'(got), 64'd1);
        if (!got) return;

        req_valid = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_write = wr;
        acc_cyc   = cyc;
        @(posedge HCLK);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'($urandom_range(0, 1));

        psel_n = 0; pen_n = 0; k = 0; got = 0; order_ok = 1; stable_ok = 1;
        while (!got && k < 100) begin
            @(negedge HCLK);
            k++;
            if (rsp_valid) begin
                got = 1;
                if (PSEL || PENABLE || req_ready) order_ok = 0;
            end else begin
                if (PSEL) psel_n++;
                if (PENABLE) pen_n++;
                if (k == 1 && !(PSEL && !PENABLE)) order_ok = 0;
                if (k >= 2 && !(PSEL && PENABLE)) order_ok = 0;
                if (req_ready) order_ok = 0;
                if (PSEL && (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr))
                    stable_ok = 0;
            end
        end
        chk({name, " rsp_seen"}, 64'(got), 64'd1);
        if (!got) return;
        chk({name, " latency"}, 64'(k), 64'(2 + access));
        chk({name, " psel_cycles"}, 64'(psel_n), 64'(access + 1));
        chk({name, " penable_cycles"}, 64'(pen_n), 64'(access));
        chk({name, " phase_order"}, 64'(order_ok), 64'd1);
        chk({name, " payload_stable"}, 64'(stable_ok), 64'd1);
        chk({name, " rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
        chk({name, " err"}, 64'(rsp_err), 64'(exp_err));
        chk({name, " timeout"}, 64'(rsp_timeout), 64'(timed_out));

        if (hold > 0) begin
            stable_ok = 1;
            for (int i = 0; i < hold; i++) begin
                @(negedge HCLK);
                if (!rsp_valid || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
                    rsp_timeout !== timed_out || PSEL || req_ready)
                    stable_ok = 0;
            end
            chk({name, " rsp_hold"}, 64'(stable_ok), 64'd1);
        end

        if (wr && !timed_out) ref_mem[addr[5:2]] = wdata;

        rsp_ready = 1'b1;
        @(posedge HCLK);
        #1;
        rsp_ready = 1'b0;
        chk({name, " rsp_released"}, 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   t0, t1, t2, tdummy;
        int   idx;
        bit   quiet;

        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        rsp_ready = 1'b0;

        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h0000_00A5;
        mem_load   = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 mem_load = 1'b0;

        // Reset values.
        @(negedge HCLK);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset psel_penable_pwrite", 64'({PSEL, PENABLE, PWRITE}), 64'd0);
        chk("reset paddr", 64'(PADDR), 64'd0);
        chk("reset pwdata", 64'(PWDATA), 64'd0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Directed scenarios.
        run_xfer("zero_wait_write", 32'h1A10_3004, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 0, tdummy);
        run_xfer("wait_read", 32'h1A10_3000, 32'h0, 1'b0, 3, 1'b0, 0, tdummy);
        run_xfer("slverr_write", 32'h1A10_3008, 32'h1234_5678, 1'b1, 0, 1'b1, 5, tdummy);
        run_xfer("timeout", 32'h1A10_300C, 32'h0, 1'b0, 1000, 1'b0, 0, tdummy);
        run_xfer("late_ready", 32'h1A10_300C, 32'h0, 1'b0, c_TO - 1, 1'b0, 0, tdummy);

        // Back-to-back with the response channel always ready.
        run_xfer("b2b_0", 32'h1A10_3004, 32'h0, 1'b0, 0, 1'b0, 0, t0);
        run_xfer("b2b_1", 32'h1A10_3008, 32'h0, 1'b0, 0, 1'b0, 0, t1);
        run_xfer("b2b_2", 32'h1A10_3010, 32'h0, 1'b0, 0, 1'b0, 0, t2);
        chk("b2b spacing_01", 64'(t1 - t0), 64'd4);
        chk("b2b spacing_12", 64'(t2 - t1), 64'd4);

        // Reset during ACCESS.
        slv_waits = 5;
        slv_err   = 1'b0;
        @(negedge HCLK);
        req_valid = 1'b1;
        req_addr  = 32'h1A10_3014;
        req_write = 1'b0;
        @(posedge HCLK);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("midreset in_access", 64'({PSEL, PENABLE}), 64'b11);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        chk("midreset outputs", 64'({PSEL, PENABLE, rsp_valid, req_ready}), 64'b0001);
        quiet = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge HCLK);
            if (rsp_valid || PSEL) quiet = 0;
        end
        chk("midreset no_response", 64'(quiet), 64'd1);
        run_xfer("after_reset", 32'h1A10_3014, 32'h0, 1'b0, 1, 1'b0, 0, tdummy);

        // Randomized traffic.
        for (int n = 0; n < 20; n++) begin
            idx = $urandom_range(0, 15);
            run_xfer($sformatf("rand%0d", n), 32'h1A10_3000 | (32'(idx) << 2),
                     $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 10),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3), tdummy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
